ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Registered round-robin arbiter that shares the single RAM port between NREQ cache requesters (instruction and data caches of each core).
- Sits between the cache_control_if cache side and the RAM model.
- Holds a grant across locked multi-word transfers (block fills/writebacks), with a bound on lock length so no requester starves.
- Replaces combinational fixed-priority muxing, so the RAM address/enable path starts from a flop.

Parameters:
- NREQ, 4, number of requesters (index 0..NREQ-1); minimum 2.
- LOCK_MAX, 8, maximum consecutive ACCESS completions one requester may take under lock before forced release.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- req_ren  input  NREQ  per-requester read request.
- req_wen  input  NREQ  per-requester write request.
- req_lock  input  NREQ  per-requester keep-grant hint; sampled at ACCESS completion.
- req_addr  input  NREQ*32  per-requester word address, requester i at bits [32i+31:32i].
- req_store  input  NREQ*32  per-requester write data, same packing.
- req_wait  output  NREQ  per-requester stall.
- req_load  output  32  read data, broadcast to all requesters.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- ramstate  input  2  RAM status from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.
- ramload  input  32  RAM read data.

Behaviour:
- Definitions:
  - active[i] = req_ren[i] | req_wen[i].
  - done = state==GRANT & ramstate==ACCESS.
- States: IDLE, GRANT. Registers: state, gnt (index), last (index), lock_cnt (width ≥ clog2(LOCK_MAX+1)).
- Reset: state=IDLE, gnt=0, last=NREQ-1 (requester 0 wins first), lock_cnt=0.
- IDLE:
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - If any active, select the first active index scanning last+1, last+2, … modulo NREQ.
  - gnt<=selected, state<=GRANT.
  - Arbitration latency is exactly 1 cycle.
- GRANT:
  - ramaddr=req_addr[gnt], ramstore=req_store[gnt].
  - ramWEN=req_wen[gnt], ramREN=req_ren[gnt] & ~req_wen[gnt]; write wins when both are set.
- GRANT, done:
  - If req_lock[gnt]=1 and lock_cnt+1<LOCK_MAX: stay GRANT, lock_cnt<=lock_cnt+1.
  - Otherwise: state<=IDLE, last<=gnt, lock_cnt<=0.
- GRANT, active[gnt]=0 (request withdrawn): state<=IDLE, last<=gnt, lock_cnt<=0. No RAM enable is driven that cycle.
- ramstate FREE, BUSY or ERROR in GRANT: hold grant, no completion. ERROR is not surfaced and the requester keeps waiting.
- req_wait[i] = active[i] & ~(done & gnt==i).
  - Non-requesting ports see 0.
  - All losing requesters see 1.
  - In IDLE every active requester sees 1.
- req_load = ramload (combinational passthrough; valid for the granted requester in its done cycle).
- Forced release: the requester that hit LOCK_MAX is the lowest priority in the next arbitration. If it is the only active requester it is regranted after the 1-cycle IDLE.
- Minimum cost per transaction: 1 IDLE cycle + RAM latency. A locked burst of k≤LOCK_MAX words pays the IDLE cycle only once.
- Reset mid-GRANT: RAM enables drop immediately (asynchronous), no completion is reported, and the requester must reissue.
- Inputs changing on the granted port mid-access are passed straight through; requesters must hold addr/data stable until wait drops.

Test Plan:
- Reset, then req_ren[2]=1, addr 0x100, RAM returns ACCESS after 2 cycles with ramload 0xDEADBEEF:
  - Cycle 1 IDLE, then ramREN=1, ramaddr=0x100.
  - req_wait[2] falls in the ACCESS cycle with req_load=0xDEADBEEF.
  - Then IDLE, last=2.
- All four active, no lock, RAM ACCESS every cycle:
  - Grants in order 0,1,2,3,0.
  - Each completion is followed by one IDLE cycle.
  - Losers hold req_wait=1 throughout.
- req_ren=req_wen=1 on port 1, req_store=0x12345678, addr 0x40:
  - ramWEN=1, ramREN=0, ramstore=0x12345678, ramaddr=0x40.
- Port 0 locked 2-word burst (addr 0x200, then 0x204) with port 1 active:
  - Both words complete back-to-back with no IDLE between.
  - Lock deasserted at the second completion; port 1 granted next.
- Port 3 holds req_lock=1 continuously, port 0 active, LOCK_MAX=8:
  - Exactly 8 completions to port 3, forced release, port 0 granted next.
  - lock_cnt returns to 0.
- nRST pulsed while in GRANT with ramstate=BUSY:
  - ramREN/ramWEN go to 0 asynchronously, state=IDLE.
  - Requester 0 wins first after release.
- Port 2 granted, ramstate=ERROR for 3 cycles, then ACCESS:
  - req_wait[2] stays 1 for 3 cycles, then completes normally.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Registered round-robin arbiter sharing one RAM port between NREQ
//            cache requesters. Holds the grant across locked multi-word
//            transfers, with a cap on consecutive locked completions.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
   parameter int NREQ     = 4,
   parameter int LOCK_MAX = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NREQ-1:0]    req_ren_i,
   input  logic [NREQ-1:0]    req_wen_i,
   input  logic [NREQ-1:0]    req_lock_i,
   input  logic [NREQ*32-1:0] req_addr_i,
   input  logic [NREQ*32-1:0] req_store_i,
   output logic [NREQ-1:0]    req_wait_o,
   output logic [31:0]        req_load_o,
   output logic               ramREN_o,
   output logic               ramWEN_o,
   output logic [31:0]        ramaddr_o,
   output logic [31:0]        ramstore_o,
   input  logic [1:0]         ramstate_i,
   input  logic [31:0]        ramload_i
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W:0] LOCK_MAX_W = (CNT_W+1)'(LOCK_MAX);

   // RAM status encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3. Only ACCESS
   // completes a transfer; every other value simply holds the grant.
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;

   logic [NREQ-1:0]   w_active;
   logic              w_done;
   logic              w_granted;
   logic [IDX_W-1:0]  w_sel_idx;
   logic              w_sel_found;
   logic [IDX_W-1:0]  w_cand;
   logic [CNT_W:0]    w_lock_nxt;
   logic              w_lock_ok;

   logic [31:0]       w_addr  [NREQ];
   logic [31:0]       w_store [NREQ];

   assign w_active  = req_ren_i | req_wen_i;
   assign w_granted = (state_q == GRANT);
   assign w_done    = w_granted & (ramstate_i == RAM_ACCESS);

   // Unpack the flat per-requester buses so the grant index selects directly.
   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_unpack
         assign w_addr[i]  = req_addr_i[32*i +: 32];
         assign w_store[i] = req_store_i[32*i +: 32];
      end
   endgenerate

   // A requester stalls unless it is the one completing this cycle.
   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_wait
         assign req_wait_o[i] = w_active[i] & ~(w_done & (gnt_q == IDX_W'(i)));
      end
   endgenerate

   // Round-robin pick: first active index after the last one served.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      w_cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (int'(last_q) + k >= NREQ) begin
            w_cand = IDX_W'(int'(last_q) + k - NREQ);
         end else begin
            w_cand = IDX_W'(int'(last_q) + k);
         end
         if (!w_sel_found && w_active[w_cand]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = w_cand;
         end
      end
   end

   // Lock continues only while the next completion stays under the cap.
   assign w_lock_nxt = {1'b0, lock_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign w_lock_ok  = (w_lock_nxt < LOCK_MAX_W);

   // Next-state logic: arbitrate in IDLE, hold or release in GRANT.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      lock_cnt_d = lock_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|w_active) begin
               gnt_d   = w_sel_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!w_active[gnt_q]) begin
               // Withdrawn request: release without a completion.
               state_d    = IDLE;
               last_d     = gnt_q;
               lock_cnt_d = '0;
            end else if (w_done) begin
               if (req_lock_i[gnt_q] && w_lock_ok) begin
                  lock_cnt_d = w_lock_nxt[CNT_W-1:0];
               end else begin
                  state_d    = IDLE;
                  last_d     = gnt_q;
                  lock_cnt_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset leaves requester 0 as the first winner.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         last_q     <= IDX_W'(NREQ - 1);
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // RAM side is driven only while granted; a write wins over a read.
   assign ramWEN_o   = w_granted & req_wen_i[gnt_q];
   assign ramREN_o   = w_granted & req_ren_i[gnt_q] & ~req_wen_i[gnt_q];
   assign ramaddr_o  = w_granted ? w_addr[gnt_q]  : 32'h0;
   assign ramstore_o = w_granted ? w_store[gnt_q] : 32'h0;
   assign req_load_o = ramload_i;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter (NREQ=4, LOCK_MAX=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   ren, wen, lock;
   logic [127:0] addr, store;
   logic [3:0]   rwait;
   logic [31:0]  rload;
   logic         ramREN, ramWEN;
   logic [31:0]  ramaddr, ramstore;
   logic [1:0]   ramstate;
   logic [31:0]  ramload;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.NREQ(4), .LOCK_MAX(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_ren_i   (ren),
      .req_wen_i   (wen),
      .req_lock_i  (lock),
      .req_addr_i  (addr),
      .req_store_i (store),
      .req_wait_o  (rwait),
      .req_load_o  (rload),
      .ramREN_o    (ramREN),
      .ramWEN_o    (ramWEN),
      .ramaddr_o   (ramaddr),
      .ramstore_o  (ramstore),
      .ramstate_i  (ramstate),
      .ramload_i   (ramload)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ren = '0; wen = '0; lock = '0; addr = '0; store = '0;
      ramstate = FREE; ramload = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      ren = 4'b1111;
      @(negedge clk);
      checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL rst_ren got=%0h exp=0", ramREN); end
      checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL rst_wen got=%0h exp=0", ramWEN); end
      checks++; if (ramaddr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%08h exp=00000000", ramaddr); end
      checks++; if (rwait !== 4'b1111) begin failures++; $display("FAIL rst_wait got=%b exp=1111", rwait); end
      do_reset();
   endtask

   task automatic test_single_read();
      do_reset();
      ren[2] = 1'b1; addr[64 +: 32] = 32'h100; ramstate = FREE;
      @(negedge clk);
      checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin failures++; $display("FAIL rd_idle got ren=%0h addr=%08h exp ren=0 addr=0", ramREN, ramaddr); end
      checks++; if (rwait !== 4'b0100) begin failures++; $display("FAIL rd_idle_wait got=%b exp=0100", rwait); end
      next_cycle();
      ramstate = BUSY;
      @(negedge clk);
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin failures++; $display("FAIL rd_grant got ren=%0h addr=%08h exp ren=1 addr=100", ramREN, ramaddr); end
      checks++; if (rwait !== 4'b0100) begin failures++; $display("FAIL rd_busy_wait got=%b exp=0100", rwait); end
      next_cycle();
      @(negedge clk);
      checks++; if (rwait !== 4'b0100) begin failures++; $display("FAIL rd_busy2_wait got=%b exp=0100", rwait); end
      next_cycle();
      ramstate = ACCESS; ramload = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (rwait !== 4'b0000) begin failures++; $display("FAIL rd_done_wait got=%b exp=0000", rwait); end
      checks++; if (rload !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_load got=%08h exp=deadbeef", rload); end
      next_cycle();
      // last should now be 2: with ports 1 and 3 both active, 3 wins.
      ren = 4'b1010; addr[32 +: 32] = 32'h11; addr[96 +: 32] = 32'h33; ramstate = FREE;
      @(negedge clk);
      checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL rd_after_idle got=%0h exp=0", ramREN); end
      next_cycle();
      @(negedge clk);
      checks++; if (ramaddr !== 32'h33) begin failures++; $display("FAIL rd_rr_last got=%08h exp=00000033", ramaddr); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_w;
      do_reset();
      ren = 4'b1111;
      for (int i = 0; i < 4; i++) addr[32*i +: 32] = 32'h1000 + 32'(4*i);
      ramstate = ACCESS;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (ramREN !== 1'b0 || rwait !== 4'b1111) begin failures++; $display("FAIL rr_idle%0d got ren=%0h wait=%b exp ren=0 wait=1111", k, ramREN, rwait); end
         next_cycle();
         @(negedge clk);
         exp_w = 4'b1111 & ~(4'b0001 << (k % 4));
         checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h1000 + 32'(4*(k % 4))) begin failures++; $display("FAIL rr_grant%0d got ren=%0h addr=%08h exp ren=1 addr=%08h", k, ramREN, ramaddr, 32'h1000 + 32'(4*(k % 4))); end
         checks++; if (rwait !== exp_w) begin failures++; $display("FAIL rr_wait%0d got=%b exp=%b", k, rwait, exp_w); end
         next_cycle();
      end
   endtask

   task automatic test_write_priority();
      do_reset();
      ren[1] = 1'b1; wen[1] = 1'b1; addr[32 +: 32] = 32'h40; store[32 +: 32] = 32'h12345678;
      ramstate = BUSY;
      next_cycle();
      @(negedge clk);
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL wr_en got wen=%0h ren=%0h exp wen=1 ren=0", ramWEN, ramREN); end
      checks++; if (ramstore !== 32'h12345678 || ramaddr !== 32'h40) begin failures++; $display("FAIL wr_data got store=%08h addr=%08h exp 12345678/00000040", ramstore, ramaddr); end
      next_cycle();
      ramstate = ACCESS;
      @(negedge clk);
      checks++; if (rwait !== 4'b0000) begin failures++; $display("FAIL wr_done got=%b exp=0000", rwait); end
   endtask

   task automatic test_lock_burst();
      do_reset();
      ren = 4'b0011; lock[0] = 1'b1; addr[0 +: 32] = 32'h200; addr[32 +: 32] = 32'h300;
      ramstate = FREE;
      next_cycle();
      ramstate = ACCESS;
      @(negedge clk);
      checks++; if (ramaddr !== 32'h200 || rwait !== 4'b0010) begin failures++; $display("FAIL lk_w0 got addr=%08h wait=%b exp 00000200/0010", ramaddr, rwait); end
      next_cycle();
      addr[0 +: 32] = 32'h204; lock[0] = 1'b0;
      @(negedge clk);
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h204) begin failures++; $display("FAIL lk_w1 got ren=%0h addr=%08h exp ren=1 addr=00000204", ramREN, ramaddr); end
      checks++; if (rwait !== 4'b0010) begin failures++; $display("FAIL lk_w1_wait got=%b exp=0010", rwait); end
      next_cycle();
      ren = 4'b0010;
      @(negedge clk);
      checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL lk_idle got=%0h exp=0", ramREN); end
      next_cycle();
      @(negedge clk);
      checks++; if (ramaddr !== 32'h300) begin failures++; $display("FAIL lk_next got=%08h exp=00000300", ramaddr); end
   endtask

   task automatic test_lock_max();
      do_reset();
      ren = 4'b1000; lock = 4'b1000; addr[96 +: 32] = 32'h3000; ramstate = ACCESS;
      next_cycle();
      ren = 4'b1001; addr[0 +: 32] = 32'h500;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h3000 || rwait !== 4'b0001) begin failures++; $display("FAIL lm_done%0d got ren=%0h addr=%08h wait=%b exp 1/00003000/0001", n, ramREN, ramaddr, rwait); end
         next_cycle();
      end
      @(negedge clk);
      checks++; if (ramREN !== 1'b0 || rwait !== 4'b1001) begin failures++; $display("FAIL lm_release got ren=%0h wait=%b exp 0/1001", ramREN, rwait); end
      checks++; if (dut.lock_cnt_q !== 4'd0) begin failures++; $display("FAIL lm_cnt got=%0d exp=0", dut.lock_cnt_q); end
      next_cycle();
      @(negedge clk);
      checks++; if (ramaddr !== 32'h500 || rwait !== 4'b1000) begin failures++; $display("FAIL lm_next got addr=%08h wait=%b exp 00000500/1000", ramaddr, rwait); end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      ren[2] = 1'b1; addr[64 +: 32] = 32'h2222; addr[0 +: 32] = 32'hAAA; ramstate = BUSY;
      next_cycle();
      #2;
      checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL rm_pre got=%0h exp=1", ramREN); end
      rst_n = 1'b0;
      #1;
      checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin failures++; $display("FAIL rm_async got ren=%0h wen=%0h addr=%08h exp 0/0/0", ramREN, ramWEN, ramaddr); end
      checks++; if (rwait !== 4'b0100) begin failures++; $display("FAIL rm_wait got=%b exp=0100", rwait); end
      @(negedge clk);
      rst_n = 1'b1;
      ren = 4'b0101;
      next_cycle();
      @(negedge clk);
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'hAAA || rwait !== 4'b0101) begin failures++; $display("FAIL rm_first got ren=%0h addr=%08h wait=%b exp 1/00000aaa/0101", ramREN, ramaddr, rwait); end
   endtask

   task automatic test_error_hold();
      do_reset();
      ren[2] = 1'b1; addr[64 +: 32] = 32'h2A0; ramstate = ERROR;
      next_cycle();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checks++; if (rwait !== 4'b0100 || ramREN !== 1'b1) begin failures++; $display("FAIL er_hold%0d got wait=%b ren=%0h exp 0100/1", n, rwait, ramREN); end
         next_cycle();
      end
      ramstate = ACCESS; ramload = 32'hCAFEF00D;
      @(negedge clk);
      checks++; if (rwait !== 4'b0000 || rload !== 32'hCAFEF00D) begin failures++; $display("FAIL er_done got wait=%b load=%08h exp 0000/cafef00d", rwait, rload); end
      next_cycle();
      ren = '0;
      @(negedge clk);
      checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL er_idle got=%0h exp=0", ramREN); end
   endtask

   task automatic test_withdraw();
      do_reset();
      ren[1] = 1'b1; addr[32 +: 32] = 32'h111; addr[64 +: 32] = 32'h222; ramstate = BUSY;
      next_cycle();
      ren = '0;
      @(negedge clk);
      checks++; if (ramREN !== 1'b0 || rwait !== 4'b0000) begin failures++; $display("FAIL wd_drop got ren=%0h wait=%b exp 0/0000", ramREN, rwait); end
      next_cycle();
      ren = 4'b0110;
      next_cycle();
      @(negedge clk);
      checks++; if (ramaddr !== 32'h222) begin failures++; $display("FAIL wd_next got=%08h exp=00000222", ramaddr); end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_priority();
      test_lock_burst();
      test_lock_max();
      test_reset_mid_grant();
      test_error_hold();
      test_withdraw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
